// File: rtl/hemaia_clk_div_sequencer.sv
// Serialised divisor-reconfiguration sequencer: quiesce a domain, load its new divisor, settle, release.
// Optional quiesce-ack timeout is compiled in with HEMAIA_CLK_SEQ_TIMEOUT_EN.
module hemaia_clk_div_sequencer #(
    parameter int unsigned NumDomains       = 4,
    parameter int unsigned MaxDivisionWidth = 4,
    parameter int unsigned DefaultDivision  = 1,
    parameter int unsigned SettleCycles     = 32,
    parameter int unsigned TimeoutCycles    = 1024,
    localparam int unsigned DW = (NumDomains > 1) ? $clog2(NumDomains) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   req_valid_i,
    output logic                                   req_ready_o,
    input  logic [DW-1:0]                          req_domain_i,
    input  logic [MaxDivisionWidth-1:0]            req_divisor_i,
    output logic                                   done_o,
    output logic                                   done_err_o,
    output logic                                   busy_o,
    output logic [NumDomains-1:0]                  hold_o,
    input  logic [NumDomains-1:0]                  hold_ack_i,
    output logic [NumDomains*MaxDivisionWidth-1:0] divisor_o,
    output logic [NumDomains-1:0]                  divisor_valid_o
);

    localparam int unsigned W  = MaxDivisionWidth;
    localparam int unsigned CW = $clog2(SettleCycles + 1);

    typedef enum logic [2:0] {IDLE, HOLD, APPLY, SETTLE, RELEASE} state_e;

    state_e                     state_q, state_d;
    logic [DW-1:0]              dom_q, dom_d;
    logic [W-1:0]               div_q, div_d;
    logic                       err_q, err_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [NumDomains*W-1:0]    divs_q, divs_d;
    logic [NumDomains-1:0]      dv_q, dv_d;

    logic [W-1:0]               div_arr [NumDomains];
    logic [NumDomains-1:0]      dom_onehot;
    logic [W-1:0]               cur_div;
    logic                       hold_active;
    logic                       ack_sel;
    logic                       req_in_range;

    // The settle window must cover two periods of the slowest divided clock.
    if (SettleCycles < 2 * (2 ** MaxDivisionWidth) || TimeoutCycles == 0) begin : g_param_check
        $error("hemaia_clk_div_sequencer: SettleCycles too small or TimeoutCycles zero");
    end

    genvar gi;
    generate
        for (gi = 0; gi < NumDomains; gi++) begin : g_dom
            assign div_arr[gi]    = divs_q[gi*W +: W];
            assign dom_onehot[gi] = (dom_q == DW'(gi));
        end
    endgenerate

    assign hold_active  = (state_q == HOLD) || (state_q == APPLY) || (state_q == SETTLE);
    assign hold_o       = hold_active ? dom_onehot : '0;
    assign ack_sel      = |(hold_ack_i & dom_onehot);
    assign req_in_range = (32'(req_domain_i) < NumDomains);

    always_comb begin
        cur_div = '0;
        for (int i = 0; i < int'(NumDomains); i++) begin
            if (req_domain_i == DW'(i)) cur_div = div_arr[i];
        end
    end

`ifdef HEMAIA_CLK_SEQ_TIMEOUT_EN
    localparam int unsigned TOW = $clog2(TimeoutCycles + 1);
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        dom_d   = dom_q;
        div_d   = div_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        divs_d  = divs_q;
        dv_d    = '0;
`ifdef HEMAIA_CLK_SEQ_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    dom_d = req_domain_i;
                    div_d = req_divisor_i;
                    err_d = 1'b0;
                    cnt_d = '0;
`ifdef HEMAIA_CLK_SEQ_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                    // Out-of-range targets and no-op changes skip straight to completion.
                    if (!req_in_range) begin
                        err_d   = 1'b1;
                        state_d = RELEASE;
                    end else if (req_divisor_i == cur_div) begin
                        state_d = RELEASE;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (ack_sel) begin
                    state_d = APPLY;
`ifdef HEMAIA_CLK_SEQ_TIMEOUT_EN
                end else if (to_cnt_q == TOW'(TimeoutCycles - 1)) begin
                    err_d   = 1'b1;
                    state_d = RELEASE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
`endif
                end
            end
            APPLY: begin
                for (int i = 0; i < int'(NumDomains); i++) begin
                    if (dom_onehot[i]) divs_d[i*W +: W] = div_q;
                end
                dv_d    = dom_onehot;
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == CW'(SettleCycles - 1)) begin
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            dom_q   <= '0;
            div_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            divs_q  <= {NumDomains{W'(DefaultDivision)}};
            dv_q    <= '0;
        end else begin
            state_q <= state_d;
            dom_q   <= dom_d;
            div_q   <= div_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            divs_q  <= divs_d;
            dv_q    <= dv_d;
        end
    end

`ifdef HEMAIA_CLK_SEQ_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) to_cnt_q <= '0;
        else       to_cnt_q <= to_cnt_d;
    end
`endif

    assign req_ready_o     = (state_q == IDLE);
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == RELEASE);
    assign done_err_o      = (state_q == RELEASE) && err_q;
    assign divisor_o       = divs_q;
    assign divisor_valid_o = dv_q;

endmodule

// File: tb/tb_hemaia_clk_div_sequencer.sv
// Directed self-checking bench for hemaia_clk_div_sequencer; five domains so that index 5 is encodable
// and out of range. Also exercises the HEMAIA_CLK_SEQ_TIMEOUT_EN build when that macro is defined.
module tb_hemaia_clk_div_sequencer;

    localparam int ND = 5;
    localparam int W  = 4;
    localparam int DW = 3;
    localparam int ST = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [DW-1:0]   req_domain_i;
    logic [W-1:0]    req_divisor_i;
    logic            done_o;
    logic            done_err_o;
    logic            busy_o;
    logic [ND-1:0]   hold_o;
    logic [ND-1:0]   hold_ack_i;
    logic [ND*W-1:0] divisor_o;
    logic [ND-1:0]   divisor_valid_o;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_div [ND];

    hemaia_clk_div_sequencer #(
        .NumDomains(ND), .MaxDivisionWidth(W), .DefaultDivision(1),
        .SettleCycles(ST), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_domain_i(req_domain_i), .req_divisor_i(req_divisor_i), .done_o(done_o),
        .done_err_o(done_err_o), .busy_o(busy_o), .hold_o(hold_o), .hold_ack_i(hold_ack_i),
        .divisor_o(divisor_o), .divisor_valid_o(divisor_valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [ND*W-1:0] exp_bus();
        logic [ND*W-1:0] r;
        for (int i = 0; i < ND; i++) r[i*W +: W] = exp_div[i];
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < ND; i++) exp_div[i] = 4'd1;
        checks++; if (divisor_o !== exp_bus()) begin errors++; $display("FAIL reset_divisor: got %h want %h", divisor_o, exp_bus()); end
        checks++; if (hold_o !== '0) begin errors++; $display("FAIL reset_hold: got %b want 0", hold_o); end
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
        rst_i = 1'b0;
        tick();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (divisor_valid_o !== '0) begin errors++; $display("FAIL reset_dv: got %b want 0", divisor_valid_o); end
        $display("reset done");
    endtask

    // Full sequence; other domains are acked while waiting to show they are ignored.
    task automatic test_normal(input logic [DW-1:0] d, input logic [W-1:0] v, input int ack_delay);
        logic [ND-1:0] oh;
        int done_n, dv_cnt, dv_n;
        oh = ND'(1) << d;
        done_n = 0; dv_cnt = 0; dv_n = 0;
        req_valid_i = 1'b1; req_domain_i = d; req_divisor_i = v;
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL norm_ready: got %b want 1", req_ready_o); end
        tick();
        req_valid_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL norm_busy: got %b want 1", busy_o); end
        checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL norm_not_ready: got %b want 0", req_ready_o); end
        checks++; if (hold_o !== oh) begin errors++; $display("FAIL norm_hold_rise: got %b want %b", hold_o, oh); end
        hold_ack_i = ~oh;
        repeat (ack_delay) begin
            tick();
            checks++; if (hold_o !== oh || done_o !== 1'b0) begin errors++; $display("FAIL norm_hold_wait: hold %b done %b want %b 0", hold_o, done_o, oh); end
        end
        hold_ack_i = oh;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (n == 3) hold_ack_i = '0;
            if (divisor_valid_o !== '0) begin
                dv_cnt++; dv_n = n;
                checks++; if (divisor_valid_o !== oh || divisor_o[d*W +: W] !== v) begin errors++; $display("FAIL norm_dv_pulse: dv %b div %h want %b %h", divisor_valid_o, divisor_o[d*W +: W], oh, v); end
            end
            if (done_o === 1'b1) begin done_n = n; break; end
            checks++; if (hold_o !== oh) begin errors++; $display("FAIL norm_hold_seq: got %b want %b at %0d", hold_o, oh, n); end
        end
        checks++; if (done_n != ST + 2) begin errors++; $display("FAIL norm_latency: got %0d want %0d", done_n, ST + 2); end
        checks++; if (dv_cnt != 1 || dv_n != 2) begin errors++; $display("FAIL norm_dv_count: got %0d at %0d want 1 at 2", dv_cnt, dv_n); end
        checks++; if (done_err_o !== 1'b0) begin errors++; $display("FAIL norm_err: got %b want 0", done_err_o); end
        checks++; if (hold_o !== '0) begin errors++; $display("FAIL norm_release_hold: got %b want 0", hold_o); end
        exp_div[d] = v;
        checks++; if (divisor_o !== exp_bus()) begin errors++; $display("FAIL norm_divisor: got %h want %h", divisor_o, exp_bus()); end
        tick();
        checks++; if (req_ready_o !== 1'b1 || done_o !== 1'b0) begin errors++; $display("FAIL norm_idle: ready %b done %b want 1 0", req_ready_o, done_o); end
        $display("req dom=%0d div=%0d done after %0d cycles", d, v, done_n);
    endtask

    // Same-divisor or out-of-range requests: immediate completion, nothing else moves.
    task automatic test_nochange(input logic [DW-1:0] d, input logic [W-1:0] v, input logic err);
        req_valid_i = 1'b1; req_domain_i = d; req_divisor_i = v;
        tick();
        req_valid_i = 1'b0;
        checks++; if (done_o !== 1'b1 || done_err_o !== err) begin errors++; $display("FAIL nochg_done: done %b err %b want 1 %b", done_o, done_err_o, err); end
        checks++; if (hold_o !== '0 || divisor_valid_o !== '0) begin errors++; $display("FAIL nochg_quiet: hold %b dv %b want 0 0", hold_o, divisor_valid_o); end
        checks++; if (divisor_o !== exp_bus()) begin errors++; $display("FAIL nochg_divisor: got %h want %h", divisor_o, exp_bus()); end
        tick();
        checks++; if (done_o !== 1'b0 || req_ready_o !== 1'b1 || divisor_valid_o !== '0) begin errors++; $display("FAIL nochg_idle: done %b ready %b dv %b", done_o, req_ready_o, divisor_valid_o); end
        $display("req dom=%0d div=%0d immediate err=%b", d, v, done_err_o);
    endtask

`ifdef HEMAIA_CLK_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int done_n, dv_seen;
        done_n = 0; dv_seen = 0;
        hold_ack_i = '0;
        req_valid_i = 1'b1; req_domain_i = 3'd0; req_divisor_i = 4'd9;
        tick();
        req_valid_i = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (divisor_valid_o !== '0) dv_seen++;
            if (done_o === 1'b1) begin done_n = n; break; end
        end
        checks++; if (done_n != TO) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", done_n, TO); end
        checks++; if (done_err_o !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", done_err_o); end
        checks++; if (dv_seen != 0 || divisor_o !== exp_bus()) begin errors++; $display("FAIL timeout_unchanged: dv %0d div %h want 0 %h", dv_seen, divisor_o, exp_bus()); end
        tick();
        $display("req dom=0 div=9 timed out after %0d cycles", done_n);
    endtask
`endif

    task automatic test_back_to_back();
        int n1, n2;
        n1 = 0; n2 = 0;
        hold_ack_i = '1;
        req_valid_i = 1'b1; req_domain_i = 3'd3; req_divisor_i = 4'd7;
        tick();
        req_domain_i = 3'd0; req_divisor_i = 4'd2;
        for (int n = 1; n <= 60; n++) begin
            tick();
            checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_backpressure: got %b want 0 at %0d", req_ready_o, n); end
            if (done_o === 1'b1) begin n1 = n; break; end
        end
        checks++; if (n1 != ST + 2) begin errors++; $display("FAIL b2b_first_latency: got %0d want %0d", n1, ST + 2); end
        exp_div[3] = 4'd7;
        tick();
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_after: got %b want 1", req_ready_o); end
        tick();
        req_valid_i = 1'b0;
        checks++; if (hold_o !== 5'b00001) begin errors++; $display("FAIL b2b_second_hold: got %b want 00001", hold_o); end
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (done_o === 1'b1) begin n2 = n; break; end
        end
        checks++; if (n2 != ST + 2 || done_err_o !== 1'b0) begin errors++; $display("FAIL b2b_second_done: got %0d err %b want %0d 0", n2, done_err_o, ST + 2); end
        exp_div[0] = 4'd2;
        checks++; if (divisor_o !== exp_bus()) begin errors++; $display("FAIL b2b_divisor: got %h want %h", divisor_o, exp_bus()); end
        hold_ack_i = '0;
        tick();
        $display("back-to-back dom=3 div=7 (%0d) then dom=0 div=2 (%0d)", n1, n2);
    endtask

    task automatic test_reset_mid();
        int done_seen;
        done_seen = 0;
        hold_ack_i = '1;
        req_valid_i = 1'b1; req_domain_i = 3'd4; req_divisor_i = 4'd3;
        tick();
        req_valid_i = 1'b0;
        repeat (4) tick();
        checks++; if (divisor_o[16 +: 4] !== 4'd3 || hold_o !== 5'b10000) begin errors++; $display("FAIL mid_settle: div %h hold %b want 3 10000", divisor_o[16 +: 4], hold_o); end
        rst_i = 1'b1;
        tick();
        for (int i = 0; i < ND; i++) exp_div[i] = 4'd1;
        checks++; if (hold_o !== '0 || divisor_o !== exp_bus()) begin errors++; $display("FAIL mid_reset_outputs: hold %b div %h want 0 %h", hold_o, divisor_o, exp_bus()); end
        checks++; if (done_o !== 1'b0 || req_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL mid_reset_ctrl: done %b ready %b busy %b", done_o, req_ready_o, busy_o); end
        tick();
        rst_i = 1'b0;
        hold_ack_i = '0;
        repeat (40) begin
            tick();
            if (done_o === 1'b1) done_seen++;
        end
        checks++; if (done_seen != 0) begin errors++; $display("FAIL mid_no_done: got %0d want 0", done_seen); end
        $display("reset during settle on dom=4");
    endtask

    initial begin
        rst_i = 1'b1; req_valid_i = 1'b0; req_domain_i = '0; req_divisor_i = '0; hold_ack_i = '0;
        test_reset();
        test_normal(3'd2, 4'd5, 4);
        test_nochange(3'd1, 4'd1, 1'b0);
        test_nochange(3'd5, 4'd9, 1'b1);
`ifdef HEMAIA_CLK_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_normal(3'd0, 4'd6, 40);
`endif
        test_normal(3'd1, 4'd0, 2);
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
